avaloon_cmps_logger: RTL and testbench
======================================

# avaloon_cmps_logger

Compass heading logger: an Avalon-MM write master that sits directly upstream of the on-chip heading RAM (5120 x 32-bit, byte-enabled, single port) and fills it as a circular buffer. Each valid heading sample is tagged with a 16-bit sequence number, buffered in a small FIFO, and written to the RAM through a standard `write`/`waitrequest` handshake. Pointer, wrap and overflow status are exported so that the Nios-side software can locate the newest entry.

## Interface
Parameters:
- `DEPTH_WORDS`, 5120: number of 32-bit words in the circular buffer.
- `BASE_ADDR`, 0: byte address of word 0 in the master's address space.
- `ADDR_W`, 15: master byte-address width.
- `FIFO_DEPTH`, 4: sample FIFO entries; must be a power of 2.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: when high, samples are accepted.
- `clear`, in, 1: synchronous clear of the logging state.
- `heading`, in, 9: heading in degrees; legal range 0..359.
- `heading_valid`, in, 1: single-cycle sample strobe.
- `m_address`, out, ADDR_W: byte address, equal to `BASE_ADDR + 4*index`.
- `m_write`, out, 1: write request.
- `m_writedata`, out, 32: data word.
- `m_byteenable`, out, 4: always 4'hF.
- `m_waitrequest`, in, 1: slave stall.
- `wr_index`, out, 13: index of the next word to be written.
- `wrapped`, out, 1: sticky flag, set when the index wraps.
- `overflow_cnt`, out, 16: saturating count of samples dropped because the FIFO was full.
- `invalid_cnt`, out, 16: saturating count of samples rejected because `heading` > 359.

## Operation
Data word format:
- `m_writedata = {seq[15:0], 7'b0, heading[8:0]}`.
- `seq` increments by 1 per accepted sample and wraps modulo 2^16.

Sample acceptance occurs when `heading_valid & enable` is high:
- `heading` > 359: the sample is dropped and `invalid_cnt` is incremented. `seq` is unchanged.
- FIFO full: the sample is dropped and `overflow_cnt` is incremented. `seq` is unchanged.
- Otherwise: the sample is pushed with the current `seq`, and `seq` is incremented.
- When `enable` is low, samples are ignored and no counter changes. The FIFO keeps draining.

State machine (states IDLE and WRITE):
- IDLE: if the FIFO is non-empty, pop one entry, latch `m_address`/`m_writedata`, and go to WRITE.
- WRITE: `m_write` = 1. Address and data are held stable while `m_waitrequest` = 1.
- A transfer completes on any edge where `m_write` & !`m_waitrequest`. On completion:
  - `wr_index` increments.
  - If the FIFO is non-empty, pop the next entry and stay in WRITE (back-to-back writes).
  - Otherwise go to IDLE.

Wrap-around:
- When `wr_index` = `DEPTH_WORDS`-1 at completion, the next value is 0 and `wrapped` is set.
- `wrapped` stays set until `clear` or reset.

Clear (`clear` high at an edge):
- The FIFO is flushed.
- `seq`, `overflow_cnt`, `invalid_cnt` and `wrapped` are set to 0, and `wr_index` is set to 0.
- An in-flight write is not aborted. It completes at its latched address and does not advance `wr_index`.
- If `clear` and a completion occur at the same edge, `clear` wins and `wr_index` = 0.
- If `clear` and a sample arrive at the same edge, `clear` wins and the sample is discarded.

Simultaneous push and pop on a full FIFO:
- The push is accepted, because the pop frees the slot at the same edge.

Counters saturate at 16'hFFFF.

## Timing
Reset values:
- `m_write` = 0, `m_address` = `BASE_ADDR`, `m_writedata` = 0, `m_byteenable` = 4'hF.
- `wr_index` = 0, `wrapped` = 0, both counters = 0, `seq` = 0, FIFO empty, state IDLE.

Latency and throughput:
- With the FIFO empty and the FSM in IDLE, a sample strobed in cycle 0 gives `m_write` high in cycle 2.
- Sustained throughput is 1 word/clk while `m_waitrequest` = 0.

Output registering:
- All outputs are registered.
- `m_write` may deassert only in the cycle after a completing edge.

Reset assertion mid-transfer forces `m_write` low immediately (asynchronous).

## Test plan
- **Single sample:** reset, `enable`=1, one strobe with `heading`=123, `m_waitrequest`=0 → `m_write` high in cycle 2 for exactly 1 cycle, `m_address`=`BASE_ADDR`, `m_writedata`=32'h0000_007B, `wr_index`=1.
- **Waitrequest stall:** hold `m_waitrequest`=1 for 5 cycles during a write → address and data stable for all 6 `m_write` cycles, exactly one completion, `wr_index` +1.
- **Overflow:** hold `m_waitrequest`=1, strobe 7 samples on consecutive cycles → 1 sample in flight plus 4 in the FIFO, `overflow_cnt`=2. After release: 5 writes with `seq` 0..4, in order.
- **Invalid heading:** strobe `heading`=360, then `heading`=359 → `invalid_cnt`=1, one write with data 32'h0000_0167 (`seq`=0).
- **Wrap:** 5121 samples with no stalls → the 5121st write goes to index 0 (`m_address`=`BASE_ADDR`), `wrapped`=1, `wr_index`=1.
- **Clear mid-write:** assert `clear` while in WRITE with `m_waitrequest`=1 and 3 entries in the FIFO → the in-flight write completes at its old address, and no further writes follow. After completion: `wr_index`=0, `wrapped`=0, counters 0, next sample gets `seq`=0.

Source files
------------

// File: rtl/avaloon_cmps_logger.sv
// avaloon_cmps_logger
//
// Compass heading logger. It tags each valid heading sample with a 16-bit
// sequence number and holds it in a small FIFO. It then writes the sample
// into a circular buffer of 32-bit words through an Avalon-MM write master.
//
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   enable             : samples are accepted only while high
//   clear              : synchronous clear of FIFO, sequence, index and status
//   heading[8:0]       : heading in degrees, legal range 0..359
//   heading_valid      : single-cycle sample strobe
//   m_address          : byte address BASE_ADDR + 4*index of the current write
//   m_write            : write request
//   m_writedata        : {seq[15:0], 7'b0, heading[8:0]}
//   m_byteenable       : constant 4'hF
//   m_waitrequest      : slave stall
//   wr_index           : index of the next word to be written
//   wrapped            : sticky, set when wr_index wraps to 0
//   overflow_cnt       : saturating count of samples dropped on a full FIFO
//   invalid_cnt        : saturating count of samples with heading > 359
module avaloon_cmps_logger #(
  parameter int DEPTH_WORDS = 5120,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 15,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [8:0]        heading,
  input  logic              heading_valid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  output logic [12:0]       wr_index,
  output logic              wrapped,
  output logic [15:0]       overflow_cnt,
  output logic [15:0]       invalid_cnt
);

  localparam int          PW          = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT  = (PW+1)'(FIFO_DEPTH);
  localparam logic [8:0]  MAX_HEADING = 9'd359;
  localparam logic [12:0] LAST_INDEX  = 13'(DEPTH_WORDS - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t state_reg, state_next;

  // FIFO entry layout: {seq[15:0], heading[8:0]}
  logic [24:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [15:0]   seq_reg;
  // The in-flight write was issued before a clear. Its completion must not
  // advance the freshly zeroed index.
  logic          no_advance_reg;

  logic        fifo_empty, fifo_full;
  logic        sample, heading_ok, complete, advance;
  logic        pop, push, drop_full, drop_invalid;
  logic [12:0] index_inc, index_after;
  logic [24:0] head;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [12:0] idx);
    return ADDR_W'(BASE_ADDR) + ADDR_W'({idx, 2'b00});
  endfunction

  assign m_byteenable = 4'hF;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_COUNT);
  assign head       = fifo_mem[rd_ptr_reg];

  // clear has priority over any sample arriving at the same edge
  assign sample       = heading_valid & enable & ~clear;
  assign heading_ok   = (heading <= MAX_HEADING);
  assign complete     = m_write & ~m_waitrequest;
  assign advance      = complete & ~no_advance_reg & ~clear;

  // A pop at the same edge frees a slot, so a push into a full FIFO is still accepted
  assign push         = sample & heading_ok & (~fifo_full | pop);
  assign drop_full    = sample & heading_ok & fifo_full & ~pop;
  assign drop_invalid = sample & ~heading_ok;

  assign index_inc   = (wr_index == LAST_INDEX) ? 13'd0 : wr_index + 13'd1;
  // A back-to-back pop targets the index that is valid after this completion
  assign index_after = advance ? index_inc : wr_index;

  // FSM next-state and pop decision
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!clear && !fifo_empty) begin
          pop        = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (complete) begin
          if (!clear && !fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sample storage has no reset so that it can map onto distributed/block RAM
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {seq_reg, heading};
    end
  end

  // FIFO pointers and sequence number
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      seq_reg    <= 16'd0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      seq_reg    <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
        seq_reg    <= seq_reg + 16'd1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Status: index, wrap flag and drop counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_index       <= 13'd0;
      wrapped        <= 1'b0;
      overflow_cnt   <= 16'd0;
      invalid_cnt    <= 16'd0;
      no_advance_reg <= 1'b0;
    end else if (clear) begin
      wr_index       <= 13'd0;
      wrapped        <= 1'b0;
      overflow_cnt   <= 16'd0;
      invalid_cnt    <= 16'd0;
      no_advance_reg <= m_write & ~complete;
    end else begin
      if (advance) begin
        wr_index <= index_inc;
        if (wr_index == LAST_INDEX) begin
          wrapped <= 1'b1;
        end
      end
      if (complete) begin
        no_advance_reg <= 1'b0;
      end
      if (drop_full && overflow_cnt != 16'hFFFF) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
      if (drop_invalid && invalid_cnt != 16'hFFFF) begin
        invalid_cnt <= invalid_cnt + 16'd1;
      end
    end
  end

  // Master outputs: address and data change only on a pop, so they stay
  // stable for the whole time the slave asserts waitrequest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_write     <= 1'b0;
      m_address   <= ADDR_W'(BASE_ADDR);
      m_writedata <= 32'd0;
    end else begin
      m_write <= (state_next == WRITE);
      if (pop) begin
        m_address   <= addr_of(index_after);
        m_writedata <= {head[24:9], 7'b0, head[8:0]};
      end
    end
  end

endmodule

// File: tb/tb_avaloon_cmps_logger.sv
// Testbench for avaloon_cmps_logger. A queue-based reference model tracks
// pending samples, the write in flight, the index and the counters. Every
// cycle the bench compares the DUT outputs with that model. Directed scenarios
// add fixed expected values.
module tb_avaloon_cmps_logger;

  localparam int DEPTH  = 5120;
  localparam int BASE   = 0;
  localparam int ADDR_W = 15;
  localparam int FDEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic [8:0]        heading = 9'd0;
  logic              heading_valid = 1'b0;
  logic [ADDR_W-1:0] m_address;
  logic              m_write;
  logic [31:0]       m_writedata;
  logic [3:0]        m_byteenable;
  logic              m_waitrequest = 1'b0;
  logic [12:0]       wr_index;
  logic              wrapped;
  logic [15:0]       overflow_cnt;
  logic [15:0]       invalid_cnt;

  avaloon_cmps_logger #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .ADDR_W(ADDR_W), .FIFO_DEPTH(FDEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .heading(heading), .heading_valid(heading_valid),
    .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .wr_index(wr_index), .wrapped(wrapped),
    .overflow_cnt(overflow_cnt), .invalid_cnt(invalid_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [24:0] mq[$];
  bit          m_busy = 0, m_wrapped = 0, m_noadv = 0;
  logic [12:0] m_idx = '0, m_cur_idx = '0;
  logic [31:0] m_cur_data = '0;
  logic [15:0] m_seq = '0, m_ovf = '0, m_inv = '0;
  bit          cmp_m, adv_m, pop_m;
  int          occ_m;
  logic [24:0] ent_m;

  initial begin : ref_model
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        m_busy = 0; m_wrapped = 0; m_noadv = 0;
        m_idx = '0; m_cur_idx = '0; m_cur_data = '0;
        m_seq = '0; m_ovf = '0; m_inv = '0;
      end else begin
        cmp_m = m_busy && !m_waitrequest;
        adv_m = cmp_m && !m_noadv && !clear;
        occ_m = mq.size();
        pop_m = !clear && occ_m > 0 && (!m_busy || cmp_m);
        if (clear) begin
          mq.delete();
          m_noadv = m_busy && !cmp_m;
          m_idx = '0; m_wrapped = 0; m_seq = '0; m_ovf = '0; m_inv = '0;
        end else begin
          if (pop_m) begin
            ent_m = mq.pop_front();
            m_cur_idx = adv_m ? ((m_idx == 13'(DEPTH - 1)) ? 13'd0 : m_idx + 13'd1) : m_idx;
            m_cur_data = {ent_m[24:9], 7'b0, ent_m[8:0]};
          end
          if (heading_valid && enable) begin
            if (heading > 9'd359) begin
              if (m_inv != 16'hFFFF) m_inv++;
            end else if (occ_m - (pop_m ? 1 : 0) < FDEPTH) begin
              mq.push_back({m_seq, heading});
              m_seq++;
            end else if (m_ovf != 16'hFFFF) begin
              m_ovf++;
            end
          end
          if (adv_m) begin
            if (m_idx == 13'(DEPTH - 1)) begin
              m_idx = 13'd0;
              m_wrapped = 1;
            end else begin
              m_idx++;
            end
          end
          if (cmp_m) m_noadv = 0;
        end
        if (!m_busy || cmp_m) m_busy = pop_m;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin : cycle_checker
    forever begin
      @(negedge clk);
      check_value("m_write", m_write, m_busy);
      if (m_busy) begin
        check_value("m_address", 32'(m_address), 32'(BASE + 4 * int'(m_cur_idx)));
        check_value("m_writedata", m_writedata, m_cur_data);
      end
      check_value("wr_index", wr_index, m_idx);
      check_value("wrapped", wrapped, m_wrapped);
      check_value("overflow_cnt", overflow_cnt, m_ovf);
      check_value("invalid_cnt", invalid_cnt, m_inv);
      check_value("m_byteenable", m_byteenable, 4'hF);
    end
  end

  // Completed transfers as seen on the bus
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  initial begin : xfer_log
    forever begin
      @(posedge clk);
      if (reset_n && m_write && !m_waitrequest) begin
        log_addr.push_back(32'(m_address));
        log_data.push_back(m_writedata);
        $display("write addr=0x%0h data=0x%08h", m_address, m_writedata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0; heading_valid = 1'b0; clear = 1'b0; m_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    check_value("rst_m_write", m_write, 0);
    check_value("rst_m_address", 32'(m_address), 32'(BASE));
    check_value("rst_m_writedata", m_writedata, 0);
    check_value("rst_wr_index", wr_index, 0);
    check_value("rst_wrapped", wrapped, 0);
    check_value("rst_counters", {overflow_cnt, invalid_cnt}, 0);
    reset_n = 1'b1;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send(input logic [8:0] h);
    heading = h;
    heading_valid = 1'b1;
    @(negedge clk);
    heading_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    heading_valid = 1'b0; clear = 1'b0; m_waitrequest = 1'b0;
    while ((m_busy || mq.size() > 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_value("drain_idle", m_write, 0);
  endtask

  logic [31:0] a0, d0;
  int          wcycles, nlog;

  initial begin
    // Single sample: latency 2, one write cycle
    do_reset;
    enable = 1'b1;
    heading = 9'd123; heading_valid = 1'b1;
    @(negedge clk);
    heading_valid = 1'b0;
    check_value("lat_cycle1", m_write, 0);
    @(negedge clk);
    check_value("lat_cycle2", m_write, 1);
    check_value("single_addr", 32'(m_address), 32'(BASE));
    check_value("single_data", m_writedata, 32'h0000_007B);
    @(negedge clk);
    check_value("single_done", m_write, 0);
    check_value("single_index", wr_index, 1);

    // Waitrequest stall: 5 stalled cycles, then completion
    m_waitrequest = 1'b1;
    nlog = log_addr.size();
    send(9'd200);
    wcycles = 0;
    for (int i = 0; i < 14; i++) begin
      if (m_write) begin
        if (wcycles == 0) begin
          a0 = 32'(m_address); d0 = m_writedata;
          check_value("stall_first_addr", a0, 32'(BASE + 4));
          check_value("stall_first_data", d0, 32'h0001_00C8);
        end else begin
          check_value("stall_addr_stable", 32'(m_address), a0);
          check_value("stall_data_stable", m_writedata, d0);
        end
        wcycles++;
        if (wcycles == 6) m_waitrequest = 1'b0;
      end
      @(negedge clk);
    end
    check_value("stall_write_cycles", wcycles, 6);
    check_value("stall_completions", log_addr.size() - nlog, 1);
    check_value("stall_index", wr_index, 2);

    // Overflow: 7 strobes against a stalled slave
    do_reset;
    enable = 1'b1; m_waitrequest = 1'b1;
    for (int i = 0; i < 7; i++) send(9'(10 + i));
    repeat (3) @(negedge clk);
    check_value("ovf_count", overflow_cnt, 2);
    drain;
    check_value("ovf_writes", log_data.size(), 5);
    for (int i = 0; i < 5 && i < log_data.size(); i++) begin
      check_value("ovf_seq", log_data[i][31:16], i);
      check_value("ovf_heading", log_data[i][8:0], 10 + i);
    end

    // Invalid heading
    do_reset;
    enable = 1'b1;
    send(9'd360);
    send(9'd359);
    drain;
    check_value("inv_count", invalid_cnt, 1);
    check_value("inv_writes", log_data.size(), 1);
    if (log_data.size() > 0) check_value("inv_data", log_data[0], 32'h0000_0167);

    // Clear while a write is stalled with 3 entries queued
    do_reset;
    enable = 1'b1;
    send(9'd1);
    send(9'd2);
    drain;
    check_value("clr_pre_index", wr_index, 2);
    log_addr.delete(); log_data.delete();
    m_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) send(9'(50 + i));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    m_waitrequest = 1'b0;
    repeat (10) @(negedge clk);
    check_value("clr_writes", log_addr.size(), 1);
    if (log_addr.size() > 0) begin
      check_value("clr_old_addr", log_addr[0], 32'(BASE + 8));
      check_value("clr_old_data", log_data[0], 32'h0002_0032);
    end
    check_value("clr_index", wr_index, 0);
    check_value("clr_wrapped", wrapped, 0);
    check_value("clr_counters", {overflow_cnt, invalid_cnt}, 0);
    send(9'd77);
    drain;
    check_value("clr_next_writes", log_addr.size(), 2);
    if (log_addr.size() > 1) begin
      check_value("clr_next_addr", log_addr[1], 32'(BASE));
      check_value("clr_next_data", log_data[1], 32'h0000_004D);
    end

    // Wrap: DEPTH+1 samples back to back
    do_reset;
    enable = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) send(9'($urandom_range(0, 359)));
    drain;
    check_value("wrap_writes", log_addr.size(), DEPTH + 1);
    if (log_addr.size() > 0) check_value("wrap_last_addr", log_addr[log_addr.size() - 1], 32'(BASE));
    check_value("wrap_flag", wrapped, 1);
    check_value("wrap_index", wr_index, 1);

    // Randomized traffic against the model
    do_reset;
    for (int i = 0; i < 3000; i++) begin
      enable        = ($urandom_range(0, 9) != 0);
      heading_valid = $urandom_range(0, 1);
      heading       = 9'($urandom_range(0, 400));
      clear         = ($urandom_range(0, 49) == 0);
      m_waitrequest = ($urandom_range(0, 9) < 3);
      @(negedge clk);
    end
    drain;

    // Asynchronous reset mid-transfer
    enable = 1'b1; m_waitrequest = 1'b1;
    send(9'd5);
    @(negedge clk);
    check_value("arst_pre_write", m_write, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("arst_write_low", m_write, 0);
    @(negedge clk);
    m_waitrequest = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
